// File: rtl/fixmul_pipe.sv
// fixmul_pipe: pipelined saturating signed fixed-point multiplier with valid/ready flow (rounding via FIXMUL_PIPE_ROUND_EN)
module fixmul_pipe #(
  parameter int WIDTH  = 19,
  parameter int FRAC   = 18,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic [TAG_W-1:0] out_tag
);
  localparam int PW = 2 * WIDTH;
  localparam int QW = PW - FRAC;
  logic             adv;
  logic             v1, s1, v2, s2;
  logic [WIDTH-1:0] ma, mb;
  logic [TAG_W-1:0] t1, t2;
  logic [PW-1:0]    prod, rnd;
  logic [QW-1:0]    q, lim, qs;
  logic             sat_c;
  logic [WIDTH-1:0] res;
  logic [STAGES:3]  v;
  logic [WIDTH-1:0] dat [3:STAGES];
  logic             sat [3:STAGES];
  logic [TAG_W-1:0] tag [3:STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = v[STAGES];
  assign out_data  = dat[STAGES];
  assign out_sat   = sat[STAGES];
  assign out_tag   = tag[STAGES];
`ifdef FIXMUL_PIPE_ROUND_EN
  assign rnd = prod + (PW'(1) << (FRAC - 1));
`else
  assign rnd = prod;
`endif
  // magnitude is clamped to the largest value representable with the result sign, then re-signed
  always_comb begin
    q     = rnd[PW-1:FRAC];
    lim   = s2 ? (QW'(1) << (WIDTH - 1)) : (QW'(1) << (WIDTH - 1)) - QW'(1);
    sat_c = q > lim;
    qs    = sat_c ? lim : q;
    res   = s2 ? -qs[WIDTH-1:0] : qs[WIDTH-1:0];
  end
  // whole pipe advances together; a stalled output freezes every stage
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      ma <= '0;
      mb <= '0;
      t1 <= '0;
      v2 <= 1'b0;
      s2 <= 1'b0;
      prod <= '0;
      t2 <= '0;
      v <= '0;
      for (int k = 3; k <= STAGES; k++) begin
        dat[k] <= '0;
        sat[k] <= 1'b0;
        tag[k] <= '0;
      end
    end else if (adv) begin
      v1 <= in_valid;
      s1 <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
      ma <= in_a[WIDTH-1] ? -in_a : in_a;
      mb <= in_b[WIDTH-1] ? -in_b : in_b;
      t1 <= in_tag;
      v2 <= v1;
      s2 <= s1;
      prod <= PW'(ma) * PW'(mb);
      t2 <= t1;
      v[3] <= v2;
      dat[3] <= res;
      sat[3] <= sat_c;
      tag[3] <= t2;
      for (int k = 4; k <= STAGES; k++) begin
        v[k] <= v[k-1];
        dat[k] <= dat[k-1];
        sat[k] <= sat[k-1];
        tag[k] <= tag[k-1];
      end
    end
  end
endmodule
